// File: rtl/sha256_channel_arbiter.sv
// Shares one sha256 engine between NUM_CH requesters.
// Arbitration is round-robin per message: a grant is held until the block
// flagged last. Grant order is recorded in an order FIFO so each returned
// hash can be steered to the channel that owns it.
//
// Ports:
//   clk, sync_rst (sync, active-high), en (low freezes all state)
//   ch_data_in*  : per-channel block streams (valid/ready/last)
//   blk_data_out*: granted stream to the engine; blk_ch_out tags the grant
//   hash_in*     : hashes returned from the engine
//   ch_hash_out* : hash broadcast, one-hot valid to the owning channel
//   busy         : a message is locked or hashes are still outstanding
module sha256_channel_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned HASH_W      = 256,
    parameter int unsigned ORDER_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        sync_rst,
    input  logic                        en,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data_in,
    input  logic [NUM_CH-1:0]           ch_data_in_last,
    input  logic [NUM_CH-1:0]           ch_data_in_valid,
    output logic [NUM_CH-1:0]           ch_data_in_ready,
    output logic [DATA_W-1:0]           blk_data_out,
    output logic                        blk_data_out_last,
    output logic                        blk_data_out_valid,
    input  logic                        blk_data_out_ready,
    output logic [$clog2(NUM_CH)-1:0]   blk_ch_out,
    input  logic [HASH_W-1:0]           hash_in,
    input  logic                        hash_in_last,
    input  logic                        hash_in_valid,
    output logic                        hash_in_ready,
    output logic [HASH_W-1:0]           ch_hash_out,
    output logic                        ch_hash_out_last,
    output logic [NUM_CH-1:0]           ch_hash_out_valid,
    input  logic [NUM_CH-1:0]           ch_hash_out_ready,
    output logic                        busy
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = $clog2(ORDER_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic [CH_W-1:0]   fifo_mem [ORDER_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [CH_W-1:0]   sel_c;
    logic              sel_found_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [CH_W-1:0]   head_c;
    logic              push_c;
    logic              pop_c;

    // Round-robin pick: first valid channel after the last one served.
    always_comb begin
        logic [CH_W-1:0] cand;
        cand        = '0;
        sel_c       = '0;
        sel_found_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((32'(rr_q) + k) % NUM_CH);
            if (!sel_found_c && ch_data_in_valid[cand]) begin
                sel_c       = cand;
                sel_found_c = 1'b1;
            end
        end
    end

    assign fifo_full_c  = (count_q == CNT_W'(ORDER_DEPTH));
    assign fifo_empty_c = (count_q == '0);
    assign head_c       = fifo_mem[rd_ptr_q];

    // Push is qualified on the registered count, so a full FIFO blocks the grant.
    assign push_c = en && (state_q == IDLE) && sel_found_c && !fifo_full_c;

    // Forward FSM: next state and pass-through of the granted channel.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_d               = rr_q;
        blk_data_out_valid = 1'b0;
        ch_data_in_ready   = '0;
        case (state_q)
            IDLE: begin
                if (push_c) begin
                    grant_d = sel_c;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                blk_data_out_valid        = en && ch_data_in_valid[grant_q];
                ch_data_in_ready[grant_q] = en && blk_data_out_ready;
                if (blk_data_out_valid && blk_data_out_ready && ch_data_in_last[grant_q]) begin
                    state_d = IDLE;
                    rr_d    = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= CH_W'(NUM_CH - 1);
        end else if (en) begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign blk_data_out      = ch_data_in[32'(grant_q)*DATA_W +: DATA_W];
    assign blk_data_out_last = ch_data_in_last[grant_q];
    assign blk_ch_out        = (state_q == LOCKED) ? grant_q : '0;

    // Return path: the FIFO head owns the hash currently coming back.
    assign hash_in_ready     = en && !fifo_empty_c && ch_hash_out_ready[head_c];
    assign ch_hash_out       = hash_in;
    assign ch_hash_out_last  = hash_in_last;
    assign ch_hash_out_valid = (en && !fifo_empty_c && hash_in_valid) ?
                               (NUM_CH'(1) << head_c) : '0;

    // Only the final hash word of a message retires its order entry.
    assign pop_c = hash_in_valid && hash_in_ready && hash_in_last;

    // Order FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Order FIFO storage; contents are don't-care while the entry is empty.
    always_ff @(posedge clk) begin
        if (!sync_rst && push_c) fifo_mem[wr_ptr_q] <= sel_c;
    end

    assign busy = (state_q == LOCKED) || (count_q != '0);

endmodule

// File: tb/tb_sha256_channel_arbiter.sv
// Directed bench for sha256_channel_arbiter with queue-based scoreboards for
// forwarded blocks and routed hashes, plus cycle-specific protocol checks.
module tb_sha256_channel_arbiter;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned DATA_W      = 512;
    localparam int unsigned HASH_W      = 256;
    localparam int unsigned ORDER_DEPTH = 8;
    localparam int unsigned W           = DATA_W;

    logic                       clk = 1'b0;
    logic                       sync_rst;
    logic                       en;
    logic [NUM_CH*DATA_W-1:0]   ch_data_in;
    logic [NUM_CH-1:0]          ch_data_in_last;
    logic [NUM_CH-1:0]          ch_data_in_valid;
    logic [NUM_CH-1:0]          ch_data_in_ready;
    logic [DATA_W-1:0]          blk_data_out;
    logic                       blk_data_out_last;
    logic                       blk_data_out_valid;
    logic                       blk_data_out_ready;
    logic [1:0]                 blk_ch_out;
    logic [HASH_W-1:0]          hash_in;
    logic                       hash_in_last;
    logic                       hash_in_valid;
    logic                       hash_in_ready;
    logic [HASH_W-1:0]          ch_hash_out;
    logic                       ch_hash_out_last;
    logic [NUM_CH-1:0]          ch_hash_out_valid;
    logic [NUM_CH-1:0]          ch_hash_out_ready;
    logic                       busy;

    always #5 clk = ~clk;

    sha256_channel_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .HASH_W(HASH_W), .ORDER_DEPTH(ORDER_DEPTH)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .en(en),
        .ch_data_in(ch_data_in), .ch_data_in_last(ch_data_in_last),
        .ch_data_in_valid(ch_data_in_valid), .ch_data_in_ready(ch_data_in_ready),
        .blk_data_out(blk_data_out), .blk_data_out_last(blk_data_out_last),
        .blk_data_out_valid(blk_data_out_valid), .blk_data_out_ready(blk_data_out_ready),
        .blk_ch_out(blk_ch_out),
        .hash_in(hash_in), .hash_in_last(hash_in_last),
        .hash_in_valid(hash_in_valid), .hash_in_ready(hash_in_ready),
        .ch_hash_out(ch_hash_out), .ch_hash_out_last(ch_hash_out_last),
        .ch_hash_out_valid(ch_hash_out_valid), .ch_hash_out_ready(ch_hash_out_ready),
        .busy(busy)
    );

    // Per-channel message source state.
    int   tx_rem   [NUM_CH];
    int   tx_idx   [NUM_CH];
    int   tx_tag   [NUM_CH];
    logic tx_stall [NUM_CH];

    function automatic logic [DATA_W-1:0] blk_word(input int tag, input int idx);
        return DATA_W'(tag * 256 + idx);
    endfunction

    always_comb begin
        ch_data_in       = '0;
        ch_data_in_last  = '0;
        ch_data_in_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_data_in[c*DATA_W +: DATA_W] = blk_word(tx_tag[c], tx_idx[c]);
            ch_data_in_last[c]             = (tx_rem[c] == 1);
            ch_data_in_valid[c]            = (tx_rem[c] != 0) && !tx_stall[c];
        end
    end

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        logic              last;
    } blk_t;

    typedef struct {
        logic [NUM_CH-1:0] onehot;
        logic [HASH_W-1:0] h;
        logic              last;
    } hash_t;

    blk_t  exp_blk[$];
    hash_t exp_hash[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_msg(input int c, input int nblk, input int tag);
        tx_rem[c]   = nblk;
        tx_idx[c]   = 0;
        tx_tag[c]   = tag;
        tx_stall[c] = 1'b0;
    endtask

    task automatic expect_msg(input int c, input int nblk, input int tag);
        for (int i = 0; i < nblk; i++)
            exp_blk.push_back('{c, blk_word(tag, i), (i == nblk - 1)});
    endtask

    task automatic send_hash(input logic [NUM_CH-1:0] oh, input int val, input logic last);
        hash_in       = HASH_W'(val);
        hash_in_last  = last;
        hash_in_valid = 1'b1;
        exp_hash.push_back('{oh, HASH_W'(val), last});
    endtask

    // One clock: note handshakes just before the edge, retire them just after.
    task automatic cycle();
        logic [NUM_CH-1:0] hs;
        logic              hh;
        #1;
        hs = ch_data_in_valid & ch_data_in_ready;
        hh = hash_in_valid & hash_in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hs[c]) begin
                tx_idx[c] = tx_idx[c] + 1;
                tx_rem[c] = tx_rem[c] - 1;
            end
        end
        if (hh) hash_in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_rem[c]   = 0;
            tx_stall[c] = 1'b0;
        end
        hash_in_valid = 1'b0;
        cycle();
        sync_rst = 1'b0;
    endtask

    task automatic drained(input string name);
        chk({name, "_blk_sb"},  W'(exp_blk.size()),  W'(0));
        chk({name, "_hash_sb"}, W'(exp_hash.size()), W'(0));
    endtask

    // Scoreboard monitor: compares every handshake against the queued expectation.
    task automatic monitor();
        blk_t  b;
        hash_t h;
        forever begin
            @(negedge clk);
            #2;
            if (!sync_rst && blk_data_out_valid && blk_data_out_ready) begin
                if (exp_blk.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL blk_unexpected: got ch %0d data %0h, expected none", blk_ch_out, blk_data_out);
                end else begin
                    b = exp_blk.pop_front();
                    chk("blk_ch",   W'(blk_ch_out),        W'(b.ch));
                    chk("blk_data", W'(blk_data_out),      W'(b.data));
                    chk("blk_last", W'(blk_data_out_last), W'(b.last));
                end
            end
            if (!sync_rst && hash_in_valid && hash_in_ready) begin
                if (exp_hash.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hash_unexpected: got valid %b, expected none", ch_hash_out_valid);
                end else begin
                    h = exp_hash.pop_front();
                    chk("hash_route", W'(ch_hash_out_valid), W'(h.onehot));
                    chk("hash_data",  W'(ch_hash_out),       W'(h.h));
                    chk("hash_last",  W'(ch_hash_out_last),  W'(h.last));
                end
            end
        end
    endtask

    initial begin
        sync_rst           = 1'b1;
        en                 = 1'b1;
        blk_data_out_ready = 1'b1;
        ch_hash_out_ready  = '1;
        hash_in            = '0;
        hash_in_last       = 1'b0;
        hash_in_valid      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            tx_rem[c] = 0; tx_idx[c] = 0; tx_tag[c] = 0; tx_stall[c] = 1'b0;
        end
        fork
            monitor();
        join_none
        @(negedge clk);

        // Reset state, then a 2-block message on ch0 and its hash.
        do_reset();
        #1;
        chk("rst_ch_ready",   W'(ch_data_in_ready),   W'(4'b0000));
        chk("rst_blk_valid",  W'(blk_data_out_valid), W'(1'b0));
        chk("rst_hash_ready", W'(hash_in_ready),      W'(1'b0));
        chk("rst_hash_valid", W'(ch_hash_out_valid),  W'(4'b0000));
        chk("rst_busy",       W'(busy),               W'(1'b0));
        chk("rst_blk_ch",     W'(blk_ch_out),         W'(0));
        load_msg(0, 2, 1);
        expect_msg(0, 2, 1);
        #1;
        chk("t1_idle_cycle", W'(blk_data_out_valid), W'(1'b0));
        cycle();
        #1;
        chk("t1_locked_valid", W'(blk_data_out_valid), W'(1'b1));
        chk("t1_locked_ch",    W'(blk_ch_out),         W'(0));
        chk("t1_locked_ready", W'(ch_data_in_ready),   W'(4'b0001));
        chk("t1_locked_busy",  W'(busy),               W'(1'b1));
        cycle();
        cycle();
        #1;
        chk("t1_done_valid", W'(blk_data_out_valid), W'(1'b0));
        chk("t1_inflight",   W'(busy),               W'(1'b1));
        send_hash(4'b0001, 32'h1111, 1'b1);
        cycle();
        #1;
        chk("t1_busy_clear", W'(busy), W'(1'b0));
        drained("t1");

        // Four simultaneous single-block messages, with an enable freeze.
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            load_msg(c, 1, 10 + c);
            expect_msg(c, 1, 10 + c);
        end
        cycle();
        en = 1'b0;
        repeat (2) begin
            #1;
            chk("t2_en_valid", W'(blk_data_out_valid), W'(1'b0));
            chk("t2_en_ready", W'(ch_data_in_ready),   W'(4'b0000));
            chk("t2_en_grant", W'(blk_ch_out),         W'(0));
            cycle();
        end
        en = 1'b1;
        repeat (7) cycle();
        #1;
        chk("t2_busy_fifo", W'(busy), W'(1'b1));
        for (int c = 0; c < NUM_CH; c++) begin
            logic [NUM_CH-1:0] oh;
            oh    = '0;
            oh[c] = 1'b1;
            send_hash(oh, 32'h2000 + c, 1'b1);
            cycle();
        end
        #1;
        chk("t2_busy_clear", W'(busy), W'(1'b0));
        drained("t2");

        // ch2 stalls mid-message; grant is held, then rr continues to ch0, ch1.
        do_reset();
        load_msg(2, 3, 20);
        expect_msg(2, 3, 20);
        cycle();
        #1;
        chk("t3_grant_ch2", W'(blk_ch_out), W'(2));
        cycle();
        load_msg(1, 1, 21);
        load_msg(0, 1, 22);
        expect_msg(0, 1, 22);
        expect_msg(1, 1, 21);
        tx_stall[2] = 1'b1;
        repeat (5) begin
            #1;
            chk("t3_ch1_ready", W'(ch_data_in_ready[1]), W'(1'b0));
            chk("t3_stall_vld", W'(blk_data_out_valid),  W'(1'b0));
            chk("t3_hold_ch2",  W'(blk_ch_out),          W'(2));
            cycle();
        end
        tx_stall[2] = 1'b0;
        repeat (3) cycle();
        #1;
        chk("t3_next_ch0", W'(blk_ch_out), W'(0));
        repeat (2) cycle();
        #1;
        chk("t3_next_ch1", W'(blk_ch_out), W'(1));
        cycle();
        drained("t3");

        // Order FIFO full: 9th message waits until one hash returns.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            load_msg(0, 1, 30 + k);
            expect_msg(0, 1, 30 + k);
            cycle();
            cycle();
        end
        load_msg(0, 1, 38);
        expect_msg(0, 1, 38);
        repeat (3) begin
            #1;
            chk("t4_full_valid", W'(blk_data_out_valid), W'(1'b0));
            chk("t4_full_ready", W'(ch_data_in_ready),   W'(4'b0000));
            chk("t4_full_busy",  W'(busy),               W'(1'b1));
            cycle();
        end
        send_hash(4'b0001, 32'h4000, 1'b1);
        cycle();
        #1;
        chk("t4_arb_cycle", W'(blk_data_out_valid), W'(1'b0));
        cycle();
        #1;
        chk("t4_granted", W'(blk_data_out_valid), W'(1'b1));
        cycle();
        drained("t4");

        // Hash back-pressure from ch1; ch0 ready must not matter.
        do_reset();
        ch_hash_out_ready = 4'b0000;
        load_msg(1, 1, 40);
        expect_msg(1, 1, 40);
        cycle();
        cycle();
        load_msg(0, 1, 41);
        expect_msg(0, 1, 41);
        cycle();
        cycle();
        ch_hash_out_ready = 4'b1111;
        send_hash(4'b0010, 32'h5001, 1'b0);
        #1;
        chk("t5_nonlast_ready", W'(hash_in_ready), W'(1'b1));
        cycle();
        ch_hash_out_ready = 4'b0001;
        send_hash(4'b0010, 32'h5002, 1'b1);
        repeat (3) begin
            #1;
            chk("t5_bp_ready", W'(hash_in_ready),     W'(1'b0));
            chk("t5_bp_valid", W'(ch_hash_out_valid), W'(4'b0010));
            cycle();
        end
        ch_hash_out_ready = 4'b0010;
        #1;
        chk("t5_rise_ready", W'(hash_in_ready), W'(1'b1));
        cycle();
        ch_hash_out_ready = 4'b0001;
        send_hash(4'b0001, 32'h5003, 1'b1);
        #1;
        chk("t5_head_ch0", W'(ch_hash_out_valid), W'(4'b0001));
        cycle();
        #1;
        chk("t5_busy_clear", W'(busy), W'(1'b0));
        drained("t5");

        // Reset while locked with two messages in flight.
        do_reset();
        ch_hash_out_ready = 4'b1111;
        load_msg(0, 1, 50);
        load_msg(1, 3, 51);
        expect_msg(0, 1, 50);
        exp_blk.push_back('{1, blk_word(51, 0), 1'b0});
        repeat (4) cycle();
        blk_data_out_ready = 1'b0;
        #1;
        chk("t6_pre_busy", W'(busy),       W'(1'b1));
        chk("t6_pre_ch",   W'(blk_ch_out), W'(1));
        do_reset();
        blk_data_out_ready = 1'b1;
        #1;
        chk("t6_post_busy",       W'(busy),             W'(1'b0));
        chk("t6_post_ch_ready",   W'(ch_data_in_ready), W'(4'b0000));
        chk("t6_post_hash_ready", W'(hash_in_ready),    W'(1'b0));
        load_msg(3, 1, 52);
        load_msg(0, 1, 53);
        expect_msg(0, 1, 53);
        expect_msg(3, 1, 52);
        repeat (4) cycle();
        drained("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_channel_arbiter.md
Name: sha256_channel_arbiter

Overview:
- Shares one sha256_engine between NUM_CH independent requesters.
- Arbitrates message-block streams round-robin at message granularity. A grant is held until the block flagged last, because compression state is per message.
- Forwards the granted stream to the engine data-in port.
- Records grant order in an internal order FIFO and steers each returned hash to the channel that owns it.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- DATA_W, 512, message block width.
- HASH_W, 256, hash width.
- ORDER_DEPTH, 8, order FIFO depth (power of 2); the maximum number of messages in flight inside the engine.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- sync_rst  in  1  synchronous reset, active-high.
- en  in  1  enable; when low, all state is frozen.
- ch_data_in  in  NUM_CH*DATA_W  per-channel blocks; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_data_in_last  in  NUM_CH  per-channel last-block-of-message flag.
- ch_data_in_valid  in  NUM_CH  per-channel valid.
- ch_data_in_ready  out  NUM_CH  per-channel ready.
- blk_data_out  out  DATA_W  block to the engine.
- blk_data_out_last  out  1  last block of the message.
- blk_data_out_valid  out  1  valid to the engine.
- blk_data_out_ready  in  1  engine ready.
- blk_ch_out  out  $clog2(NUM_CH)  index of the channel currently granted (debug/tag).
- hash_in  in  HASH_W  hash from the engine.
- hash_in_last  in  1  final hash word of a message.
- hash_in_valid  in  1  hash valid.
- hash_in_ready  out  1  hash ready.
- ch_hash_out  out  HASH_W  hash broadcast to all channels.
- ch_hash_out_last  out  1  broadcast last.
- ch_hash_out_valid  out  NUM_CH  one-hot valid for the owning channel.
- ch_hash_out_ready  in  NUM_CH  per-channel ready.
- busy  out  1  high when the FSM is LOCKED or the order FIFO is non-empty.

Behaviour:
- Reset (sync_rst=1 at a clk edge):
  - state=IDLE, rr_ptr=NUM_CH-1, so channel 0 has first priority.
  - Order FIFO empty (rd_ptr=wr_ptr=count=0), grant=0.
  - Every ready/valid output is 0; busy=0.
  - Reset mid-message abandons it. The engine must be reset in the same cycle.
- en=0: no register updates. All valid/ready outputs are forced 0, so no handshake can occur. Data outputs hold their values.
- Forward FSM, IDLE:
  - If any ch_data_in_valid is set and order FIFO count<ORDER_DEPTH, select the first valid channel searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - At that edge: grant<=sel, push sel into the order FIFO, go to LOCKED.
  - No data moves in the IDLE cycle (1 cycle of arbitration overhead per message).
  - Order FIFO full: stay in IDLE, no grant.
- Forward FSM, LOCKED:
  - Pure combinational pass-through of channel g=grant:
    - blk_data_out/last/valid = channel g signals.
    - ch_data_in_ready[g] = blk_data_out_ready; all other channel readies = 0.
  - On a handshake with last=1: state<=IDLE, rr_ptr<=g.
  - A channel dropping valid mid-message keeps its grant; there is no timeout.
- blk_ch_out = grant while LOCKED, 0 otherwise. blk_data_out_valid=0 in IDLE.
- Return path (active when the order FIFO is non-empty; head h = channel at rd_ptr):
  - ch_hash_out = hash_in; ch_hash_out_last = hash_in_last.
  - ch_hash_out_valid = onehot(h) & hash_in_valid.
  - hash_in_ready = ch_hash_out_ready[h].
  - When the FIFO is empty: hash_in_ready=0 and all ch_hash_out_valid=0.
  - A hash handshake with hash_in_last=1 pops the FIFO. Non-last hash words do not pop.
- Order FIFO:
  - Pointers are $clog2(ORDER_DEPTH) bits and wrap modulo the depth; count is $clog2(ORDER_DEPTH)+1 bits.
  - Same-cycle push and pop leaves count unchanged. This is legal even at full: the push is qualified on the registered count, so when full no grant occurs that cycle.
  - A pop when empty cannot occur, because hash_in_ready=0.
  - A hash returning in the same cycle as its grant cannot occur; the engine latency is at least 1.
- busy = (state==LOCKED) | (count!=0).

Test Plan:
- Reset, then ch0 sends a 2-block message, engine ready=1 -> IDLE cycle, then 2 blocks forwarded on consecutive cycles with blk_ch_out=0; one hash returns -> ch_hash_out_valid=4'b0001, FIFO pops, busy returns to 0.
- All 4 channels assert 1-block messages simultaneously -> grants in order 0,1,2,3, each taking 2 cycles (grant + transfer); hashes routed to 0001, 0010, 0100, 1000 in that order.
- Ch2 is granted and mid-message while ch1 asserts valid; ch2 then stalls valid for 5 cycles -> ch1 ready stays 0 throughout; ch2 completes; the next grant goes to ch3 if it is valid, otherwise ch0, otherwise ch1.
- Engine never returns hashes; 9 single-block messages are offered with ORDER_DEPTH=8 -> 8 grants occur and the 9th waits in IDLE. One hash returns -> the 9th is granted on the next cycle.
- Hash destined for ch1 with ch_hash_out_ready[1]=0 for 3 cycles -> hash_in_ready=0 for those 3 cycles; pop only on the cycle ready rises; ch0 ready has no effect.
- Assert sync_rst while LOCKED with 2 entries in the FIFO -> on the next cycle state=IDLE, count=0, all valids/readies 0; the next arbitration starts at ch0.
